cruise_speed_controller: RTL and testbench
==========================================

Name: cruise_speed_controller

Overview:
Top-level cruise-control sequencer. It latches a driver set-speed and arbitrates between driver inputs (set, resume, cancel, brake, pedal, adjust). It sequences the existing eight_bit_comparator each cycle to compare measured speed against the set-speed with a deadband. It drives registered throttle-up and throttle-down commands, debounced by a settle counter.

Parameters:
MIN_SPEED, 8'd40, lowest speed at which cruise may engage; lower bound for adjust saturation
MAX_SPEED, 8'd200, highest engageable speed; upper bound for adjust saturation
STEP, 8'd1, set-speed change per inc/dec pulse
DEADBAND, 8'd2, tolerance band around the set-speed in which no throttle command is issued
SETTLE_CYCLES, 4, consecutive identical comparison results required before the throttle command changes (at least 1)

Ports:
clk  in  1  system clock, rising edge
rst_n  in  1  asynchronous active-low reset
power  in  1  cruise master switch (level)
set_btn  in  1  one-cycle pulse; engage at current speed
resume_btn  in  1  one-cycle pulse; re-engage at the stored set-speed
cancel_btn  in  1  one-cycle pulse; disengage
brake  in  1  brake pedal (level)
accel_pedal  in  1  driver throttle override (level)
inc_btn  in  1  one-cycle pulse; raise set-speed by STEP
dec_btn  in  1  one-cycle pulse; lower set-speed by STEP
speed  in  8  measured vehicle speed, unsigned
set_speed  out  8  stored target speed
set_valid  out  1  set_speed holds a usable value
cruise_active  out  1  state is CRUISE
throttle_up  out  1  request acceleration
throttle_down  out  1  request deceleration
state_o  out  2  current state: OFF=0, STANDBY=1, CRUISE=2, OVERRIDE=3

Behaviour:
- Clock and reset: one clock, clk. rst_n is asynchronous and active-low.
- Reset values: state OFF; set_speed 0; set_valid 0; cruise_active 0; throttle_up 0; throttle_down 0; settle counter 0.
- Reset asserted mid-operation returns every output to its reset value immediately, not at the next clock edge.
- speed is registered once on entry. All decisions use the registered speed, spd_r.
- Global: power=0 forces OFF from any state and clears set_valid.
- OFF: power=1 -> STANDBY.
- STANDBY, checked in priority order:
  - brake=1: no transition.
  - set_btn with MIN_SPEED<=spd_r<=MAX_SPEED: set_speed=spd_r, set_valid=1 -> CRUISE.
  - resume_btn with set_valid=1 -> CRUISE.
  - set_btn with spd_r out of range: ignored.
- CRUISE, priority brake > cancel > accel_pedal > inc/dec:
  - brake or cancel -> STANDBY; set_speed is retained.
  - accel_pedal -> OVERRIDE.
  - inc_btn and dec_btn in the same cycle: both ignored.
  - Adjust saturates at MIN_SPEED and MAX_SPEED. Use 9-bit arithmetic so the result never wraps.
- OVERRIDE: brake or cancel -> STANDBY; accel_pedal=0 -> CRUISE. inc/dec are ignored.
- Comparator sequencing:
  - Two eight_bit_comparator instances. One compares spd_r+DEADBAND against set_speed (low check); the other compares spd_r against set_speed+DEADBAND (high check).
  - Each operand is saturated to 8'hFF when the 9-bit sum carries.
  - Comparator enable = (state==CRUISE).
  - Raw decision: ACCEL if the low check gives L; DECEL if the high check gives G; else HOLD.
- Settle counter:
  - Counts consecutive cycles in which the raw decision equals the previous cycle's raw decision; resets to 0 when the decision changes.
  - When the counter reaches SETTLE_CYCLES-1, the throttle outputs take the decision on the next edge.
  - Latency from a speed change to a throttle change: 1 (input register) + SETTLE_CYCLES cycles.
- throttle_up and throttle_down are never both 1. Both are 0 and the counter is cleared in any state other than CRUISE, and in the same cycle CRUISE is left.
- cruise_active is registered and equals (next state==CRUISE).

Optional Feature:
CRUISE_AUTO_CANCEL_EN
- Defined: in CRUISE, if spd_r<MIN_SPEED for SETTLE_CYCLES consecutive cycles, the block goes to STANDBY and keeps set_valid. This shares the settle-counter style; it uses a separate counter.
- Undefined: low speed only produces ACCEL requests; the state never changes automatically.

Decomposition:
- Package cruise_pkg holds:
  - state typedef / localparams OFF, STANDBY, CRUISE, OVERRIDE
  - decision encoding HOLD, ACCEL, DECEL
  - default speed constants
- Sub-module cruise_decision: comparator pair, deadband saturation and settle counter, producing throttle_up and throttle_down. The FSM and set-speed register remain in the top module.

Test Plan:
- Reset/power: rst_n low mid-CRUISE -> all outputs 0 and state_o=0 asynchronously. power=1 -> state_o=1 next cycle.
- Engage: speed=60, set_btn -> set_speed=60, set_valid=1, state_o=2. speed=30 with set_btn -> remains STANDBY.
- Deadband/settle: set=60, SETTLE=4. speed=57 held -> throttle_up=1 exactly 5 cycles after the speed change. speed=61 -> HOLD (both 0). speed=63 -> throttle_down=1.
- Override and brake: accel_pedal=1 -> state_o=3 with throttles 0; release -> CRUISE. brake -> STANDBY with set_speed kept; resume_btn -> CRUISE at 60.
- Adjust saturation: set=199 with inc x3 -> 200. set=40 with dec -> 40. inc and dec in the same cycle -> unchanged.
- CRUISE_AUTO_CANCEL_EN: set=45, speed drops to 35 for 4 cycles -> STANDBY with set_valid=1. With the macro undefined -> stays CRUISE with throttle_up=1.

Source files
------------

// File: rtl/cruise_pkg.sv
// Shared types and defaults for the cruise-control sequencer.
// Optional build macro: CRUISE_AUTO_CANCEL_EN (see cruise_speed_controller).
package cruise_pkg;

   typedef enum logic [1:0] {
      OFF      = 2'd0,
      STANDBY  = 2'd1,
      CRUISE   = 2'd2,
      OVERRIDE = 2'd3
   } state_e;

   typedef enum logic [1:0] {
      HOLD  = 2'd0,
      ACCEL = 2'd1,
      DECEL = 2'd2
   } decision_e;

   localparam logic [7:0] MIN_SPEED_DEF     = 8'd40;
   localparam logic [7:0] MAX_SPEED_DEF     = 8'd200;
   localparam logic [7:0] STEP_DEF          = 8'd1;
   localparam logic [7:0] DEADBAND_DEF      = 8'd2;
   localparam int         SETTLE_CYCLES_DEF = 4;

   // Unsigned 8-bit add that clamps to 8'hFF instead of wrapping.
   function automatic logic [7:0] sat_add8(input logic [7:0] a, input logic [7:0] b);
      logic [8:0] sum;
      sum = {1'b0, a} + {1'b0, b};
      return sum[8] ? 8'hFF : sum[7:0];
   endfunction

endpackage

// File: rtl/cruise_decision.sv
// Deadband comparison of speed against set-speed, debounced by a settle counter
// into registered throttle_up / throttle_down commands.
import cruise_pkg::*;

module cruise_decision #(
   parameter logic [7:0] DEADBAND      = DEADBAND_DEF,
   parameter int         SETTLE_CYCLES = SETTLE_CYCLES_DEF
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       cmp_en,
   input  logic       run,
   input  logic [7:0] spd,
   input  logic [7:0] set_speed,
   output logic       throttle_up,
   output logic       throttle_down
);

   localparam logic [7:0] SETTLE_LAST = 8'(SETTLE_CYCLES - 1);

   logic [7:0] low_a;
   logic [7:0] high_b;
   logic       lo_lt, lo_gt, hi_lt, hi_gt;
   logic       unused_cmp;
   decision_e  raw;
   decision_e  prev_d, prev_q;
   logic [7:0] cnt_d, cnt_q;
   logic       up_d, up_q;
   logic       down_d, down_q;

   assign low_a  = sat_add8(spd, DEADBAND);
   assign high_b = sat_add8(set_speed, DEADBAND);

   eight_bit_comparator u_cmp_low (
      .en (cmp_en),
      .a  (low_a),
      .b  (set_speed),
      .lt (lo_lt),
      .gt (lo_gt)
   );

   eight_bit_comparator u_cmp_high (
      .en (cmp_en),
      .a  (spd),
      .b  (high_b),
      .lt (hi_lt),
      .gt (hi_gt)
   );

   assign unused_cmp = lo_gt ^ hi_lt;

   always_comb begin
      raw = HOLD;
      if (lo_lt) begin
         raw = ACCEL;
      end else if (hi_gt) begin
         raw = DECEL;
      end
   end

   // Outputs only follow the raw decision once it has been stable long enough.
   always_comb begin
      prev_d = raw;
      cnt_d  = cnt_q;
      up_d   = up_q;
      down_d = down_q;
      if (!run) begin
         prev_d = HOLD;
         cnt_d  = 8'd0;
         up_d   = 1'b0;
         down_d = 1'b0;
      end else begin
         if (raw != prev_q) begin
            cnt_d = 8'd0;
         end else if (cnt_q < SETTLE_LAST) begin
            cnt_d = cnt_q + 8'd1;
         end
         if (cnt_d == SETTLE_LAST) begin
            up_d   = (raw == ACCEL);
            down_d = (raw == DECEL);
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         prev_q <= HOLD;
         cnt_q  <= 8'd0;
         up_q   <= 1'b0;
         down_q <= 1'b0;
      end else begin
         prev_q <= prev_d;
         cnt_q  <= cnt_d;
         up_q   <= up_d;
         down_q <= down_d;
      end
   end

   assign throttle_up   = up_q;
   assign throttle_down = down_q;

endmodule

// File: rtl/eight_bit_comparator.sv
// Unsigned 8-bit magnitude comparator; both flags are forced low when disabled.
module eight_bit_comparator (
   input  logic       en,
   input  logic [7:0] a,
   input  logic [7:0] b,
   output logic       lt,
   output logic       gt
);

   always_comb begin
      lt = 1'b0;
      gt = 1'b0;
      if (en) begin
         lt = (a < b);
         gt = (a > b);
      end
   end

endmodule

// File: rtl/cruise_speed_controller.sv
// Cruise-control sequencer: driver-input arbitration FSM and set-speed register.
// Optional build macro: CRUISE_AUTO_CANCEL_EN (drop to STANDBY after sustained low speed).
//
// state    | meaning
// OFF      | master switch off, set-speed invalid
// STANDBY  | powered, waiting for set/resume
// CRUISE   | regulating speed toward set_speed
// OVERRIDE | driver pedal overrides, throttles idle
import cruise_pkg::*;

module cruise_speed_controller #(
   parameter logic [7:0] MIN_SPEED     = MIN_SPEED_DEF,
   parameter logic [7:0] MAX_SPEED     = MAX_SPEED_DEF,
   parameter logic [7:0] STEP          = STEP_DEF,
   parameter logic [7:0] DEADBAND      = DEADBAND_DEF,
   parameter int         SETTLE_CYCLES = SETTLE_CYCLES_DEF
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       power,
   input  logic       set_btn,
   input  logic       resume_btn,
   input  logic       cancel_btn,
   input  logic       brake,
   input  logic       accel_pedal,
   input  logic       inc_btn,
   input  logic       dec_btn,
   input  logic [7:0] speed,
   output logic [7:0] set_speed,
   output logic       set_valid,
   output logic       cruise_active,
   output logic       throttle_up,
   output logic       throttle_down,
   output logic [1:0] state_o
);

   state_e     state_d, state_q;
   logic [7:0] spd_q;
   logic [7:0] set_speed_d, set_speed_q;
   logic       set_valid_d, set_valid_q;
   logic       cruise_active_q;
   logic       in_range;
   logic [8:0] inc_sum;
   logic [8:0] dec_floor;
   logic       auto_cancel;

   assign in_range  = (spd_q >= MIN_SPEED) && (spd_q <= MAX_SPEED);
   assign inc_sum   = {1'b0, set_speed_q} + {1'b0, STEP};
   assign dec_floor = {1'b0, MIN_SPEED} + {1'b0, STEP};

`ifdef CRUISE_AUTO_CANCEL_EN
   localparam logic [7:0] LOW_LAST = 8'(SETTLE_CYCLES - 1);
   logic       low_now;
   logic [7:0] low_cnt_d, low_cnt_q;

   assign low_now     = (state_q == CRUISE) && (spd_q < MIN_SPEED);
   assign auto_cancel = low_now && (low_cnt_q == LOW_LAST);
   assign low_cnt_d   = (low_now && !auto_cancel) ? low_cnt_q + 8'd1 : 8'd0;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         low_cnt_q <= 8'd0;
      end else begin
         low_cnt_q <= low_cnt_d;
      end
   end
`else
   assign auto_cancel = 1'b0;
`endif

   always_comb begin
      state_d     = state_q;
      set_speed_d = set_speed_q;
      set_valid_d = set_valid_q;
      if (!power) begin
         state_d     = OFF;
         set_valid_d = 1'b0;
      end else begin
         case (state_q)
            OFF: state_d = STANDBY;
            STANDBY: begin
               if (!brake) begin
                  if (set_btn && in_range) begin
                     set_speed_d = spd_q;
                     set_valid_d = 1'b1;
                     state_d     = CRUISE;
                  end else if (resume_btn && set_valid_q) begin
                     state_d = CRUISE;
                  end
               end
            end
            CRUISE: begin
               if (brake || cancel_btn || auto_cancel) begin
                  state_d = STANDBY;
               end else if (accel_pedal) begin
                  state_d = OVERRIDE;
               end else if (inc_btn && !dec_btn) begin
                  set_speed_d = (inc_sum > {1'b0, MAX_SPEED}) ? MAX_SPEED : inc_sum[7:0];
               end else if (dec_btn && !inc_btn) begin
                  set_speed_d = ({1'b0, set_speed_q} < dec_floor) ? MIN_SPEED
                                                                 : set_speed_q - STEP;
               end
            end
            OVERRIDE: begin
               if (brake || cancel_btn) begin
                  state_d = STANDBY;
               end else if (!accel_pedal) begin
                  state_d = CRUISE;
               end
            end
            default: state_d = OFF;
         endcase
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q         <= OFF;
         spd_q           <= 8'd0;
         set_speed_q     <= 8'd0;
         set_valid_q     <= 1'b0;
         cruise_active_q <= 1'b0;
      end else begin
         state_q         <= state_d;
         spd_q           <= speed;
         set_speed_q     <= set_speed_d;
         set_valid_q     <= set_valid_d;
         cruise_active_q <= (state_d == CRUISE);
      end
   end

   // Throttles are held clear on the very edge that leaves CRUISE.
   cruise_decision #(
      .DEADBAND      (DEADBAND),
      .SETTLE_CYCLES (SETTLE_CYCLES)
   ) u_decision (
      .clk           (clk),
      .rst_n         (rst_n),
      .cmp_en        (state_q == CRUISE),
      .run           ((state_q == CRUISE) && (state_d == CRUISE)),
      .spd           (spd_q),
      .set_speed     (set_speed_q),
      .throttle_up   (throttle_up),
      .throttle_down (throttle_down)
   );

   assign set_speed     = set_speed_q;
   assign set_valid     = set_valid_q;
   assign cruise_active = cruise_active_q;
   assign state_o       = state_q;

endmodule

// File: tb/tb_cruise_speed_controller.sv
// Directed bench for cruise_speed_controller with hand-computed expectations.
// Expectations for the low-speed case follow CRUISE_AUTO_CANCEL_EN.
module tb_cruise_speed_controller;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic       power = 1'b0;
   logic       set_btn = 1'b0;
   logic       resume_btn = 1'b0;
   logic       cancel_btn = 1'b0;
   logic       brake = 1'b0;
   logic       accel_pedal = 1'b0;
   logic       inc_btn = 1'b0;
   logic       dec_btn = 1'b0;
   logic [7:0] speed = 8'd0;
   logic [7:0] set_speed;
   logic       set_valid;
   logic       cruise_active;
   logic       throttle_up;
   logic       throttle_down;
   logic [1:0] state_o;

   int n_tests = 0;
   int n_fail  = 0;

   cruise_speed_controller dut (
      .clk           (clk),
      .rst_n         (rst_n),
      .power         (power),
      .set_btn       (set_btn),
      .resume_btn    (resume_btn),
      .cancel_btn    (cancel_btn),
      .brake         (brake),
      .accel_pedal   (accel_pedal),
      .inc_btn       (inc_btn),
      .dec_btn       (dec_btn),
      .speed         (speed),
      .set_speed     (set_speed),
      .set_valid     (set_valid),
      .cruise_active (cruise_active),
      .throttle_up   (throttle_up),
      .throttle_down (throttle_down),
      .state_o       (state_o)
   );

   always #5 clk = ~clk;

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d", tag, got, exp);
      end
   endtask

   task automatic tick(input int n);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic press_set();
      set_btn = 1'b1; tick(1); set_btn = 1'b0;
   endtask

   task automatic press_cancel();
      cancel_btn = 1'b1; tick(1); cancel_btn = 1'b0;
   endtask

   task automatic press_inc();
      inc_btn = 1'b1; tick(1); inc_btn = 1'b0;
   endtask

   task automatic press_dec();
      dec_btn = 1'b1; tick(1); dec_btn = 1'b0;
   endtask

   initial begin
      #12;
      check_eq("rst_state", state_o, 0);
      check_eq("rst_set_speed", set_speed, 0);
      check_eq("rst_set_valid", set_valid, 0);
      check_eq("rst_active", cruise_active, 0);
      check_eq("rst_thr", {throttle_up, throttle_down}, 0);
      rst_n = 1'b1;

      power = 1'b1;
      tick(1);
      check_eq("power_standby", state_o, 1);

      speed = 8'd30; tick(1);
      press_set();
      check_eq("set_low_state", state_o, 1);
      check_eq("set_low_valid", set_valid, 0);

      speed = 8'd60; tick(1);
      press_set();
      check_eq("engage_state", state_o, 2);
      check_eq("engage_speed", set_speed, 60);
      check_eq("engage_valid", set_valid, 1);
      check_eq("engage_active", cruise_active, 1);
      tick(6);
      check_eq("hold_at_set", {throttle_up, throttle_down}, 0);

      speed = 8'd57; tick(4);
      check_eq("accel_early", throttle_up, 0);
      tick(1);
      check_eq("accel_on", {throttle_up, throttle_down}, 2'b10);

      speed = 8'd61; tick(4);
      check_eq("hold_early", throttle_up, 1);
      tick(1);
      check_eq("hold_61", {throttle_up, throttle_down}, 0);

      speed = 8'd63; tick(5);
      check_eq("decel_63", {throttle_up, throttle_down}, 2'b01);

      accel_pedal = 1'b1; tick(1);
      check_eq("ovr_state", state_o, 3);
      check_eq("ovr_thr", {throttle_up, throttle_down}, 0);
      check_eq("ovr_active", cruise_active, 0);
      accel_pedal = 1'b0; tick(1);
      check_eq("ovr_release", state_o, 2);
      speed = 8'd60; tick(6);
      check_eq("hold_after_ovr", {throttle_up, throttle_down}, 0);

      brake = 1'b1; tick(1); brake = 1'b0;
      check_eq("brake_state", state_o, 1);
      check_eq("brake_keep_speed", set_speed, 60);
      check_eq("brake_keep_valid", set_valid, 1);
      resume_btn = 1'b1; tick(1); resume_btn = 1'b0;
      check_eq("resume_state", state_o, 2);
      check_eq("resume_speed", set_speed, 60);

      press_cancel();
      check_eq("cancel_state", state_o, 1);
      speed = 8'd199; tick(1);
      press_set();
      check_eq("set_199", set_speed, 199);
      press_inc();
      check_eq("inc_to_200", set_speed, 200);
      press_inc();
      press_inc();
      check_eq("inc_sat_200", set_speed, 200);
      inc_btn = 1'b1; dec_btn = 1'b1; tick(1); inc_btn = 1'b0; dec_btn = 1'b0;
      check_eq("inc_dec_both", set_speed, 200);
      press_dec();
      check_eq("dec_to_199", set_speed, 199);

      press_cancel();
      speed = 8'd40; tick(1);
      press_set();
      check_eq("set_40", set_speed, 40);
      press_dec();
      check_eq("dec_sat_40", set_speed, 40);
      press_inc();
      check_eq("inc_to_41", set_speed, 41);

      press_cancel();
      speed = 8'd45; tick(1);
      press_set();
      check_eq("set_45", set_speed, 45);
      speed = 8'd35;
`ifdef CRUISE_AUTO_CANCEL_EN
      tick(4);
      check_eq("autocancel_early", state_o, 2);
      tick(1);
      check_eq("autocancel_state", state_o, 1);
      check_eq("autocancel_valid", set_valid, 1);
      check_eq("autocancel_thr", {throttle_up, throttle_down}, 0);
`else
      tick(5);
      check_eq("lowspd_up", throttle_up, 1);
      tick(3);
      check_eq("lowspd_state", state_o, 2);
`endif

      power = 1'b0; tick(1);
      check_eq("poweroff_state", state_o, 0);
      check_eq("poweroff_valid", set_valid, 0);
      power = 1'b1; tick(1);
      check_eq("repower_state", state_o, 1);

      speed = 8'd60; tick(1);
      press_set();
      speed = 8'd57; tick(5);
      check_eq("pre_rst_up", throttle_up, 1);
      #2;
      rst_n = 1'b0;
      #1;
      check_eq("async_rst_state", state_o, 0);
      check_eq("async_rst_speed", set_speed, 0);
      check_eq("async_rst_valid", set_valid, 0);
      check_eq("async_rst_active", cruise_active, 0);
      check_eq("async_rst_thr", {throttle_up, throttle_down}, 0);
      rst_n = 1'b1;
      tick(1);
      check_eq("post_rst_standby", state_o, 1);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
